// File: rtl/muller_c_element.sv
// Clocked Muller C-element bank: each lane output follows a/b only when they agree.
// Define C_ELEMENT_AGREE_FILTER_EN to require agreement on two consecutive edges before switching.

module muller_c_lane #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  output logic c,
  output logic rise,
  output logic fall
);
  logic c_nxt;

`ifdef C_ELEMENT_AGREE_FILTER_EN
  logic pend;
  logic want;

  // want: inputs agree on a value different from the current output
  assign want  = (a == b) && (a != c);
  assign c_nxt = (want && pend) ? a : c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= 1'b0;
    else        pend <= want && !pend;
  end
`else
  assign c_nxt = (a & b) | (c & (a | b));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c    <= RESET_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      c    <= c_nxt;
      rise <= c_nxt & ~c;
      fall <= ~c_nxt & c;
    end
  end
endmodule

module muller_c_element #(
  parameter int   LANES     = 3,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  output logic [LANES-1:0] c,
  output logic [LANES-1:0] rise,
  output logic [LANES-1:0] fall
);
  // one independent cell per lane; an X on one lane cannot reach another
  muller_c_lane #(.RESET_VAL(RESET_VAL)) u_lane [LANES-1:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .c    (c),
    .rise (rise),
    .fall (fall)
  );
endmodule

// File: tb/tb_muller_c_element.sv
// Randomized bench for muller_c_element against a lane-by-lane agreement model.
// Honours C_ELEMENT_AGREE_FILTER_EN (model requires 2 consecutive agreeing edges).

module tb_muller_c_element;
  localparam int LANES = 3;
`ifdef C_ELEMENT_AGREE_FILTER_EN
  localparam int NEED = 2;
`else
  localparam int NEED = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [LANES-1:0] a, b, c, rise, fall;

  muller_c_element #(.LANES(LANES), .RESET_VAL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .rise(rise), .fall(fall)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [LANES-1:0] m_c, m_rise, m_fall;
  int run [LANES];

  task automatic chk(input string name, input logic [LANES-1:0] got, input logic [LANES-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_c = '0; m_rise = '0; m_fall = '0;
    for (int i = 0; i < LANES; i++) run[i] = 0;
  endtask

  // Per lane: count consecutive edges where a==b and differs from the output;
  // once the count reaches NEED the output takes the agreed value.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      m_rise = '0; m_fall = '0;
      for (int i = 0; i < LANES; i++) begin
        if (a[i] == b[i] && a[i] != m_c[i]) run[i]++;
        else run[i] = 0;
        if (run[i] >= NEED) begin
          if (a[i]) m_rise[i] = 1'b1;
          else      m_fall[i] = 1'b1;
          m_c[i] = a[i];
          run[i] = 0;
        end
      end
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
  endtask

  task automatic cyc(input logic [LANES-1:0] na, input logic [LANES-1:0] nb);
    @(negedge clk);
    #1 a = na; b = nb;
    edge_step();
  endtask

  task automatic release_rst();
    @(negedge clk);
    #1 rst_n = 1'b1;
    edge_step();
  endtask

  task automatic mid_reset();
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_c", c, 3'b000);
    chk("async_rst_pulse", rise | fall, 3'b000);
  endtask

  logic chk_on = 1'b0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_c", c, m_c);
      chk("model_rise", rise, m_rise);
      chk("model_fall", fall, m_fall);
    end
  end

  initial begin
    rst_n = 1'b0; a = 3'b111; b = 3'b111;
    model_reset();
    #1;
    chk("reset_c", c, 3'b000);
    chk("reset_rise", rise, 3'b000);
    chk("reset_fall", fall, 3'b000);
    chk_on = 1'b1;
    edge_step(); edge_step();

    release_rst();
`ifndef C_ELEMENT_AGREE_FILTER_EN
    #1;
    chk("release_c", c, 3'b111);
    chk("release_rise", rise, 3'b111);

    cyc(3'b000, 3'b000);
    #1 chk("to_zero_fall", fall, 3'b111);
    // hold: inputs disagree for 5 cycles
    repeat (5) cyc(3'b111, 3'b000);
    #1 chk("hold_c", c, 3'b000);
    cyc(3'b111, 3'b111);
    #1 chk("hold_then_agree_c", c, 3'b111);

    cyc(3'b000, 3'b000);
    cyc(3'b111, 3'b101);
    #1 chk("indep_c", c, 3'b101);
    chk("indep_rise", rise, 3'b101);
    cyc(3'b000, 3'b000);
    #1 chk("indep_fall", fall, 3'b101);
    chk("indep_c0", c, 3'b000);

    cyc(3'b111, 3'b111);
    cyc(3'b011, 3'b110);
    #1 chk("fall_hold_c", c, 3'b111);
    cyc(3'b000, 3'b000);
    #1 chk("fall_hold_fall", fall, 3'b111);

    cyc(3'b111, 3'b111);
    mid_reset();
    cyc(3'b111, 3'b111);
    release_rst();
    #1 chk("after_async_c", c, 3'b111);
`else
    repeat (2) cyc(3'b000, 3'b000);
    cyc(3'b001, 3'b001);
    cyc(3'b001, 3'b000);
    #1 chk("filter_reject_c", c, 3'b000);
    cyc(3'b001, 3'b001);
    #1 chk("filter_first_c", c, 3'b000);
    cyc(3'b001, 3'b001);
    #1 chk("filter_second_c", c, 3'b001);
    chk("filter_second_rise", rise, 3'b001);
    mid_reset();
    release_rst();
`endif

    for (int n = 0; n < 400; n++) begin
      cyc(LANES'($urandom_range(0, 7)), LANES'($urandom_range(0, 7)));
      if ($urandom_range(0, 39) == 0) begin
        mid_reset();
        release_rst();
      end
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
